// File: rtl/lpc_host_io_pkg.sv
// LPC host I/O engine shared definitions: LAD codes, FSM encodings, wait classes.
// Pure declarations; no timing or flow control of its own.
package lpc_host_io_pkg;

  localparam logic [3:0] LAD_START     = 4'b0000;
  localparam logic [3:0] CYCTYPE_IO_RD = 4'b0000;
  localparam logic [3:0] CYCTYPE_IO_WR = 4'b0010;
  localparam logic [3:0] SYNC_READY    = 4'b0000;
  localparam logic [3:0] SYNC_SWAIT    = 4'b0101;
  localparam logic [3:0] SYNC_LWAIT    = 4'b0110;
  localparam logic [3:0] SYNC_ERR      = 4'b1010;
  localparam logic [3:0] SYNC_NONE     = 4'b1111;
  localparam logic [3:0] LAD_IDLE      = 4'b1111;

  typedef enum logic [3:0] {
    ST_IDLE, ST_START, ST_CYC, ST_ADDR, ST_WDATA, ST_HTAR,
    ST_SYNC, ST_RDATA, ST_PTAR, ST_ABORT, ST_DONE
  } state_t;

  typedef enum logic [1:0] {WT_NONE, WT_SHORT, WT_LONG, WT_NODEV} wait_t;

  function automatic wait_t wait_class(input logic [3:0] code);
    case (code)
      SYNC_SWAIT: return WT_SHORT;
      SYNC_LWAIT: return WT_LONG;
      SYNC_NONE:  return WT_NODEV;
      default:    return WT_NONE;
    endcase
  endfunction

  // Address goes out most significant nibble first.
  function automatic logic [3:0] addr_nibble(input logic [15:0] a, input logic [1:0] idx);
    case (idx)
      2'd0:    return a[15:12];
      2'd1:    return a[11:8];
      2'd2:    return a[7:4];
      default: return a[3:0];
    endcase
  endfunction

endpackage

// File: rtl/lpc_host_io_if.sv
// Local request handshake plus LPC bus pins of the host engine.
// master = the engine; slave = requester and peripheral side.
interface lpc_host_io_if;
  logic        req;
  logic        wr;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        busy;
  logic        done;
  logic [7:0]  rdata;
  logic        sync_err;
  logic        abort;
  logic        lframe_n;
  logic [3:0]  lad_out;
  logic        lad_oe;
  logic [3:0]  lad_in;

  modport master (
    input  req, wr, addr, wdata, lad_in,
    output busy, done, rdata, sync_err, abort, lframe_n, lad_out, lad_oe
  );

  modport slave (
    output req, wr, addr, wdata, lad_in,
    input  busy, done, rdata, sync_err, abort, lframe_n, lad_out, lad_oe
  );
endinterface

// File: rtl/lpc_host_io.sv
// LPC host engine for single I/O read/write cycles; 15 clk req->done with zero-wait SYNC.
// req is only sampled in IDLE; the peripheral stretches the cycle with wait SYNCs up to the abort limits.
module lpc_host_io
  import lpc_host_io_pkg::*;
#(
  parameter int unsigned NOSYNC_MAX = 3,
  parameter int unsigned SWAIT_MAX  = 8,
  parameter int unsigned LWAIT_MAX  = 1024,
  parameter int unsigned ABORT_LEN  = 4
) (
  input  logic          lclk,
  input  logic          lreset_n,
  lpc_host_io_if.master bus
);

  state_t      state_q, state_d;
  logic [3:0]  nib_q, nib_d;
  logic [9:0]  wcnt_q, wcnt_d;
  wait_t       wtype_q, wtype_d;
  logic        wr_q, wr_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [3:0]  rlo_q, rlo_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        serr_q, serr_d;
  logic        abort_q, abort_d;
  logic        lframe_q, lframe_d;
  logic [3:0]  lad_q, lad_d;
  logic        oe_q, oe_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  wait_t       code_t;
  logic [9:0]  lim_m1;

  // Counter holds (waits seen in this run) - 1, so LWAIT_MAX-1 still fits in 10 bits.
  assign code_t = wait_class(bus.lad_in);
  assign lim_m1 = (code_t == WT_SHORT) ? 10'(SWAIT_MAX - 1) :
                  (code_t == WT_LONG)  ? 10'(LWAIT_MAX - 1) : 10'(NOSYNC_MAX - 1);

  always_ff @(posedge lclk or negedge lreset_n) begin
    if (!lreset_n) begin
      state_q  <= ST_IDLE;
      nib_q    <= '0;
      wcnt_q   <= '0;
      wtype_q  <= WT_NONE;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rlo_q    <= '0;
      rdata_q  <= '0;
      serr_q   <= 1'b0;
      abort_q  <= 1'b0;
      lframe_q <= 1'b1;
      lad_q    <= LAD_IDLE;
      oe_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      nib_q    <= nib_d;
      wcnt_q   <= wcnt_d;
      wtype_q  <= wtype_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rlo_q    <= rlo_d;
      rdata_q  <= rdata_d;
      serr_q   <= serr_d;
      abort_q  <= abort_d;
      lframe_q <= lframe_d;
      lad_q    <= lad_d;
      oe_q     <= oe_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    nib_d   = nib_q;
    wcnt_d  = wcnt_q;
    wtype_d = wtype_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rlo_d   = rlo_q;
    rdata_d = rdata_q;
    serr_d  = serr_q;
    abort_d = abort_q;
    case (state_q)
      ST_IDLE: if (bus.req) begin
        wr_d    = bus.wr;
        addr_d  = bus.addr;
        wdata_d = bus.wdata;
        serr_d  = 1'b0;
        abort_d = 1'b0;
        state_d = ST_START;
      end
      ST_START: state_d = ST_CYC;
      ST_CYC: begin
        state_d = ST_ADDR;
        nib_d   = '0;
      end
      ST_ADDR: if (nib_q == 4'd3) begin
        state_d = wr_q ? ST_WDATA : ST_HTAR;
        nib_d   = '0;
      end else nib_d = nib_q + 4'd1;
      ST_WDATA: if (nib_q == 4'd1) begin
        state_d = ST_HTAR;
        nib_d   = '0;
      end else nib_d = nib_q + 4'd1;
      ST_HTAR: if (nib_q == 4'd1) begin
        state_d = ST_SYNC;
        nib_d   = '0;
        wcnt_d  = '0;
        wtype_d = WT_NONE;
      end else nib_d = nib_q + 4'd1;
      ST_SYNC: case (bus.lad_in)
        SYNC_READY, SYNC_ERR: begin
          serr_d  = (bus.lad_in == SYNC_ERR);
          state_d = wr_q ? ST_PTAR : ST_RDATA;
          nib_d   = '0;
        end
        SYNC_SWAIT, SYNC_LWAIT, SYNC_NONE: begin
          if (wtype_q != code_t) begin
            wtype_d = code_t;
            wcnt_d  = '0;
          end else if (wcnt_q == lim_m1) begin
            state_d = ST_ABORT;
            nib_d   = '0;
            abort_d = 1'b1;
          end else wcnt_d = wcnt_q + 10'd1;
        end
        default: begin
          state_d = ST_ABORT;
          nib_d   = '0;
          abort_d = 1'b1;
        end
      endcase
      ST_RDATA: if (nib_q == 4'd0) begin
        rlo_d = bus.lad_in;
        nib_d = 4'd1;
      end else begin
        rdata_d = {bus.lad_in, rlo_q};
        state_d = ST_PTAR;
        nib_d   = '0;
      end
      ST_PTAR: if (nib_q == 4'd1) state_d = ST_DONE;
               else nib_d = nib_q + 4'd1;
      ST_ABORT: if (nib_q == 4'(ABORT_LEN - 1)) state_d = ST_DONE;
                else nib_d = nib_q + 4'd1;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Bus pins are decoded from the next state so they register in step with it.
  always_comb begin
    lframe_d = 1'b1;
    lad_d    = LAD_IDLE;
    oe_d     = 1'b1;
    case (state_d)
      ST_START: begin
        lframe_d = 1'b0;
        lad_d    = LAD_START;
      end
      ST_CYC:   lad_d = wr_q ? CYCTYPE_IO_WR : CYCTYPE_IO_RD;
      ST_ADDR:  lad_d = addr_nibble(addr_q, nib_d[1:0]);
      ST_WDATA: lad_d = nib_d[0] ? wdata_q[7:4] : wdata_q[3:0];
      ST_HTAR:  oe_d  = (nib_d == 4'd0);
      ST_SYNC, ST_RDATA, ST_PTAR: oe_d = 1'b0;
      ST_ABORT: lframe_d = 1'b0;
      default: ;
    endcase
    busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
    done_d = (state_d == ST_DONE);
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.rdata    = rdata_q;
  assign bus.sync_err = serr_q;
  assign bus.abort    = abort_q;
  assign bus.lframe_n = lframe_q;
  assign bus.lad_out  = lad_q;
  assign bus.lad_oe   = oe_q;

endmodule

// File: tb/tb_lpc_host_io.sv
// Bench for lpc_host_io: scripted peripheral on LAD, scoreboard of expected per-cycle results.
module tb_lpc_host_io;

  logic lclk = 1'b0;
  logic lreset_n = 1'b0;

  lpc_host_io_if bus();

  lpc_host_io dut (
    .lclk     (lclk),
    .lreset_n (lreset_n),
    .bus      (bus)
  );

  initial forever #5 lclk = ~lclk;

  typedef struct {
    int         lat;
    logic [7:0] rdata;
    logic       serr;
    logic       abrt;
    int         frame_lo;
    bit         trace;
  } exp_t;

  exp_t       sb_q[$];
  logic [3:0] bfm_q[$];
  logic [4:0] exp_trace [10] = '{5'h00, 5'h02, 5'h00, 5'h00, 5'h08, 5'h00,
                                 5'h05, 5'h0A, 5'h0F, 5'h10};
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, got, got, want, want);
    end
  endtask

  task automatic bfm_push(input logic [3:0] v, input int reps);
    for (int i = 0; i < reps; i++) bfm_q.push_back(v);
  endtask

  task automatic push_exp(input int lat, input logic [7:0] rd, input logic se,
                          input logic ab, input int flo, input bit tr);
    exp_t e;
    e.lat = lat; e.rdata = rd; e.serr = se; e.abrt = ab; e.frame_lo = flo; e.trace = tr;
    sb_q.push_back(e);
  endtask

  task automatic issue(input logic w, input logic [15:0] a, input logic [7:0] d);
    @(negedge lclk);
    bus.req = 1'b1; bus.wr = w; bus.addr = a; bus.wdata = d;
    @(negedge lclk);
    bus.req = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!bus.done && n < 3000) begin
      @(negedge lclk);
      n++;
    end
    check({name, "_done_seen"}, int'(bus.done), 1);
    @(negedge lclk);
    @(negedge lclk);
  endtask

  // Peripheral model: drives the next scripted nibble whenever the host has released LAD.
  initial begin
    bus.lad_in = 4'hF;
    forever begin
      @(negedge lclk);
      if (lreset_n && bus.busy && !bus.lad_oe && bfm_q.size() > 0) bus.lad_in = bfm_q.pop_front();
      else bus.lad_in = 4'hF;
    end
  end

  bit         mon_in_txn = 1'b0;
  logic       mon_busy_prev = 1'b0;
  int         mon_cnt = 0;
  int         mon_flo = 0;
  logic [4:0] mon_tr[$];

  // Latency is counted in the clocks of req and done inclusive: busy rises one clock after req.
  initial begin
    exp_t e;
    int   bad;
    forever begin
      @(negedge lclk);
      if (!lreset_n) begin
        mon_in_txn = 1'b0;
        mon_busy_prev = 1'b0;
      end else begin
        if (bus.busy && !mon_busy_prev) begin
          mon_in_txn = 1'b1;
          mon_cnt = 0;
          mon_flo = 0;
          mon_tr.delete();
        end
        mon_busy_prev = bus.busy;
        if (mon_in_txn) begin
          if (bus.busy) mon_tr.push_back(bus.lad_oe ? {1'b0, bus.lad_out} : 5'h10);
          if (!bus.lframe_n) mon_flo++;
          if (bus.done) begin
            mon_in_txn = 1'b0;
            if (sb_q.size() == 0) check("unexpected_done", 1, 0);
            else begin
              e = sb_q.pop_front();
              check("latency", mon_cnt + 2, e.lat);
              check("rdata", int'(bus.rdata), int'(e.rdata));
              check("sync_err", int'(bus.sync_err), int'(e.serr));
              check("abort", int'(bus.abort), int'(e.abrt));
              check("lframe_low_clks", mon_flo, e.frame_lo);
              check("busy_at_done", int'(bus.busy), 0);
              if (e.trace) begin
                bad = 0;
                for (int i = 0; i < 10; i++)
                  if (i >= mon_tr.size() || mon_tr[i] !== exp_trace[i]) bad++;
                check("lad_trace_bad_nibbles", bad, 0);
              end
            end
          end
          mon_cnt++;
        end else if (bus.done) check("done_without_busy", 1, 0);
      end
    end
  end

  initial begin
    int n;
    bus.req = 1'b0; bus.wr = 1'b0; bus.addr = '0; bus.wdata = '0;
    #12;
    check("rst_lframe_n", int'(bus.lframe_n), 1);
    check("rst_lad_out", int'(bus.lad_out), 15);
    check("rst_lad_oe", int'(bus.lad_oe), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_rdata", int'(bus.rdata), 0);
    check("rst_sync_err", int'(bus.sync_err), 0);
    check("rst_abort", int'(bus.abort), 0);
    @(negedge lclk);
    lreset_n = 1'b1;
    @(negedge lclk);
    @(negedge lclk);
    check("idle_lad_oe", int'(bus.lad_oe), 1);

    // Zero-wait write; LAD trace 0,2,0,0,8,0,5,A,F,Z.
    bfm_push(4'hF, 1); bfm_push(4'h0, 1);
    push_exp(15, 8'h00, 1'b0, 1'b0, 1, 1'b1);
    issue(1'b1, 16'h0080, 8'hA5); wait_done("wr_0080");

    // Read with two short waits.
    bfm_push(4'hF, 1); bfm_push(4'h5, 2); bfm_push(4'h0, 1); bfm_push(4'hC, 1); bfm_push(4'h3, 1);
    push_exp(17, 8'h3C, 1'b0, 1'b0, 1, 1'b0);
    issue(1'b0, 16'h03F8, 8'h00); wait_done("rd_03f8");

    // No device: four 1111 SYNCs then abort, rdata held.
    push_exp(18, 8'h3C, 1'b0, 1'b1, 5, 1'b0);
    issue(1'b0, 16'h0A81, 8'h00); wait_done("rd_nodev");

    // Error SYNC on a write still completes normally.
    bfm_push(4'hF, 1); bfm_push(4'hA, 1);
    push_exp(15, 8'h3C, 1'b1, 1'b0, 1, 1'b0);
    issue(1'b1, 16'h02F8, 8'h5A); wait_done("wr_syncerr");

    // Exactly SWAIT_MAX short waits are tolerated; sync_err cleared by new req.
    bfm_push(4'hF, 1); bfm_push(4'h5, 8); bfm_push(4'h0, 1); bfm_push(4'h1, 1); bfm_push(4'h2, 1);
    push_exp(23, 8'h21, 1'b0, 1'b0, 1, 1'b0);
    issue(1'b0, 16'h0061, 8'h00); wait_done("rd_swait8");

    // One more short wait aborts.
    bfm_push(4'hF, 1); bfm_push(4'h5, 9);
    push_exp(23, 8'h21, 1'b0, 1'b1, 5, 1'b0);
    issue(1'b0, 16'h0062, 8'h00); wait_done("rd_swait9");

    // Switching wait type restarts the count: 8 short, 1 long, 1 short, ready.
    bfm_push(4'hF, 1); bfm_push(4'h5, 8); bfm_push(4'h6, 1); bfm_push(4'h5, 1);
    bfm_push(4'h0, 1); bfm_push(4'h4, 2);
    push_exp(25, 8'h44, 1'b0, 1'b0, 1, 1'b0);
    issue(1'b0, 16'h0063, 8'h00); wait_done("rd_wswitch");

    // Unknown SYNC code aborts at once.
    bfm_push(4'hF, 1); bfm_push(4'h3, 1);
    push_exp(15, 8'h44, 1'b0, 1'b1, 5, 1'b0);
    issue(1'b0, 16'h0064, 8'h00); wait_done("rd_badsync");

    // LWAIT_MAX+1 long waits abort; req held high the whole time starts one more cycle only after done.
    bfm_push(4'hF, 1); bfm_push(4'h6, 1025);
    bfm_push(4'hF, 1); bfm_push(4'h0, 1); bfm_push(4'h7, 1); bfm_push(4'hE, 1);
    push_exp(1039, 8'h44, 1'b0, 1'b1, 5, 1'b0);
    push_exp(15, 8'hE7, 1'b0, 1'b0, 1, 1'b0);
    @(negedge lclk);
    bus.req = 1'b1; bus.wr = 1'b0; bus.addr = 16'h0060;
    @(negedge lclk);
    n = 0;
    while (!bus.done && n < 3000) begin
      @(negedge lclk);
      n++;
    end
    check("lwait_done_seen", int'(bus.done), 1);
    n = 0;
    do begin
      @(negedge lclk);
      n++;
    end while (!bus.busy && n < 10);
    check("held_req_restart", int'(bus.busy), 1);
    bus.req = 1'b0;
    wait_done("rd_held_req");
    check("bfm_script_consumed", bfm_q.size(), 0);

    // Reset during the third address nibble releases the bus immediately.
    issue(1'b1, 16'h1234, 8'h00);
    repeat (4) @(negedge lclk);
    #2 lreset_n = 1'b0;
    #1;
    check("midrst_lframe_n", int'(bus.lframe_n), 1);
    check("midrst_lad_oe", int'(bus.lad_oe), 0);
    check("midrst_busy", int'(bus.busy), 0);
    check("midrst_rdata", int'(bus.rdata), 0);
    @(negedge lclk);
    @(negedge lclk);
    #2 lreset_n = 1'b1;
    @(negedge lclk);
    @(negedge lclk);

    bfm_push(4'hF, 1); bfm_push(4'h0, 1); bfm_push(4'h9, 1); bfm_push(4'h6, 1);
    push_exp(15, 8'h69, 1'b0, 1'b0, 1, 1'b0);
    issue(1'b0, 16'h0070, 8'h00); wait_done("rd_after_rst");

    check("scoreboard_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
